// File: rtl/sht40_pkg.sv
// Shared types and constants for the SHT40 measurement-frame parser.
package sht40_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_MSB,
    ST_T_LSB,
    ST_T_CRC,
    ST_H_MSB,
    ST_H_LSB,
    ST_H_CRC
  } state_e;

  // Must track the I2C master's own state encoding.
  localparam logic [2:0] MASTER_RECEIVE = 3'b011;

  localparam logic [7:0] CRC_POLY_DFLT = 8'h31;
  localparam logic [7:0] CRC_INIT_DFLT = 8'hFF;

  localparam int unsigned TEMP_SCALE  = 17500;
  localparam int unsigned TEMP_OFFSET = 4500;
  localparam int unsigned HUM_SCALE   = 12500;
  localparam int unsigned HUM_OFFSET  = 600;
  localparam int unsigned HUM_MAX     = 10000;

  typedef struct packed {
    logic [15:0] temp;
    logic [15:0] hum;
  } sample_t;

  // One MSB-first shift of a non-reflected CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/sht40_crc8_serial.sv
// Bit-serial CRC-8: one data bit per clock, result valid 8 cycles after load.
module sht40_crc8_serial
  import sht40_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DFLT,
  parameter logic [7:0] CRC_INIT = CRC_INIT_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       seed,
  input  logic [7:0] byte_in,
  output logic       busy,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q, crc_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;

  // A load restarts the engine even if a previous byte is still shifting.
  always_comb begin
    crc_d = crc_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      crc_d = seed ? CRC_INIT : crc_q;
      sh_d  = byte_in;
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      crc_d = crc8_step(crc_q, sh_q[7], CRC_POLY);
      sh_d  = {sh_q[6:0], 1'b0};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
      sh_q  <= 8'h00;
      cnt_q <= 4'd0;
    end else begin
      crc_q <= crc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy    = (cnt_q != 4'd0);
  assign crc_out = crc_q;

endmodule

// File: rtl/sht40_frame_parser.sv
// Parses the 6-byte SHT40 measurement frame, checks both CRC words, publishes raw samples.
// Optional macro SHT40_CONVERT_EN adds registered centi-degree / centi-percent outputs.
module sht40_frame_parser
  import sht40_pkg::*;
#(
  parameter logic [7:0]  CRC_POLY       = CRC_POLY_DFLT,
  parameter logic [7:0]  CRC_INIT       = CRC_INIT_DFLT,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         master_state,
  input  logic [3:0]         bytes_received,
  input  logic [7:0]         data_received,
  output logic [15:0]        temp_raw,
  output logic [15:0]        hum_raw,
  output logic               sample_valid,
  output logic               crc_error,
  output logic               frame_abort
`ifdef SHT40_CONVERT_EN
  ,
  output logic signed [15:0] temp_centi_c,
  output logic [15:0]        hum_centi_pct
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  ms_q;
  logic [3:0]  cnt_q;
  sample_t     shadow_q, shadow_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] temp_raw_q, temp_raw_d;
  logic [15:0] hum_raw_q, hum_raw_d;
  logic        sv_q, sv_d;
  logic        crc_err_q, crc_err_d;
  logic        abort_q, abort_d;

  logic        byte_stb;
  logic        frame_start;
  logic        eng_load, eng_seed, eng_busy;
  logic [7:0]  eng_crc;

  assign byte_stb    = (bytes_received != cnt_q);
  assign frame_start = (master_state == MASTER_RECEIVE) && (ms_q != MASTER_RECEIVE);

  sht40_crc8_serial #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (eng_load),
    .seed    (eng_seed),
    .byte_in (data_received),
    .busy    (eng_busy),
    .crc_out (eng_crc)
  );

  // Frame sequencing; a start always wins over a coincident byte.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    tmo_d      = tmo_q;
    temp_raw_d = temp_raw_q;
    hum_raw_d  = hum_raw_q;
    sv_d       = 1'b0;
    crc_err_d  = 1'b0;
    abort_d    = 1'b0;
    eng_load   = 1'b0;
    eng_seed   = 1'b0;

    if (frame_start) begin
      state_d = ST_T_MSB;
      tmo_d   = '0;
    end else if (state_q != ST_IDLE) begin
      if (byte_stb) begin
        tmo_d = '0;
        if (eng_busy && state_q != ST_T_MSB) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          unique case (state_q)
            ST_T_MSB: begin
              shadow_d.temp[15:8] = data_received;
              eng_load = 1'b1;
              eng_seed = 1'b1;
              state_d  = ST_T_LSB;
            end
            ST_T_LSB: begin
              shadow_d.temp[7:0] = data_received;
              eng_load = 1'b1;
              state_d  = ST_T_CRC;
            end
            ST_T_CRC: begin
              if (data_received == eng_crc) begin
                state_d = ST_H_MSB;
              end else begin
                crc_err_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end
            ST_H_MSB: begin
              shadow_d.hum[15:8] = data_received;
              eng_load = 1'b1;
              eng_seed = 1'b1;
              state_d  = ST_H_LSB;
            end
            ST_H_LSB: begin
              shadow_d.hum[7:0] = data_received;
              eng_load = 1'b1;
              state_d  = ST_H_CRC;
            end
            ST_H_CRC: begin
              if (data_received == eng_crc) begin
                temp_raw_d = shadow_q.temp;
                hum_raw_d  = shadow_q.hum;
                sv_d       = 1'b1;
              end else begin
                crc_err_d = 1'b1;
              end
              state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        abort_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ms_q       <= 3'b000;
      cnt_q      <= 4'd0;
      shadow_q   <= '0;
      tmo_q      <= '0;
      temp_raw_q <= 16'h0000;
      hum_raw_q  <= 16'h0000;
      sv_q       <= 1'b0;
      crc_err_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_q       <= master_state;
      cnt_q      <= bytes_received;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
      temp_raw_q <= temp_raw_d;
      hum_raw_q  <= hum_raw_d;
      sv_q       <= sv_d;
      crc_err_q  <= crc_err_d;
      abort_q    <= abort_d;
    end
  end

  assign temp_raw    = temp_raw_q;
  assign hum_raw     = hum_raw_q;
  assign crc_error   = crc_err_q;
  assign frame_abort = abort_q;

`ifdef SHT40_CONVERT_EN
  logic [31:0]        t_prod, h_prod;
  logic [15:0]        t_int, h_int;
  logic signed [15:0] temp_centi_d, temp_centi_q;
  logic [15:0]        hum_centi_d, hum_centi_q;
  logic               sv2_q;

  // Fixed-point scaling of the freshly loaded raw words.
  always_comb begin
    t_prod       = 32'(temp_raw_q) * 32'(TEMP_SCALE);
    h_prod       = 32'(hum_raw_q) * 32'(HUM_SCALE);
    t_int        = 16'(t_prod >> 16);
    h_int        = 16'(h_prod >> 16);
    temp_centi_d = $signed(t_int - 16'(TEMP_OFFSET));
    hum_centi_d  = 16'h0000;
    if (h_int < 16'(HUM_OFFSET)) begin
      hum_centi_d = 16'h0000;
    end else if ((h_int - 16'(HUM_OFFSET)) > 16'(HUM_MAX)) begin
      hum_centi_d = 16'(HUM_MAX);
    end else begin
      hum_centi_d = h_int - 16'(HUM_OFFSET);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_centi_q <= 16'sh0000;
      hum_centi_q  <= 16'h0000;
      sv2_q        <= 1'b0;
    end else begin
      sv2_q <= sv_q;
      if (sv_q) begin
        temp_centi_q <= temp_centi_d;
        hum_centi_q  <= hum_centi_d;
      end
    end
  end

  assign temp_centi_c  = temp_centi_q;
  assign hum_centi_pct = hum_centi_q;
  assign sample_valid  = sv2_q;
`else
  assign sample_valid  = sv_q;
`endif

endmodule
